// File: rtl/tri_gram_mult.sv
// tri_gram_mult: A_inv = Linv^T * Linv on one signed MAC, upper triangle computed and mirrored.
module tri_gram_mult #(
  parameter int N = 3,
  parameter int W = 8,
  parameter int AW = 2*W+4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W*N*N-1:0]  L_inv_in,
  output logic              busy,
  output logic              done,
  output logic [AW*N*N-1:0] A_inv_out
);
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N-1);
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
  state_t state;
  logic [CW-1:0] i, j, k;
  logic signed [W-1:0] lm [N][N];
  logic signed [AW-1:0] res [N][N];
  logic signed [AW-1:0] q [N][N];
  logic signed [AW-1:0] acc, prod, sum;
  assign prod = AW'(lm[k][i]) * AW'(lm[k][j]);
  assign sum = acc + prod;
  always_comb begin
    A_inv_out = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        A_inv_out[AW*(r*N+c) +: AW] = q[r][c];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      acc <= '0;
      i <= '0;
      j <= '0;
      k <= '0;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          lm[r][c] <= '0;
          res[r][c] <= '0;
          q[r][c] <= '0;
        end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          // above-diagonal bits are dropped at capture so the MAC never sees them
          for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
              lm[r][c] <= (c <= r) ? L_inv_in[W*(r*N+c) +: W] : '0;
          i <= '0;
          j <= '0;
          k <= '0;
          acc <= '0;
          busy <= 1'b1;
          state <= CALC;
        end
        CALC: if (k == LAST) begin
          res[i][j] <= sum;
          res[j][i] <= sum;
          acc <= '0;
          if (j != LAST) begin
            j <= j + 1'b1;
            k <= j + 1'b1;
          end else if (i != LAST) begin
            i <= i + 1'b1;
            j <= i + 1'b1;
            k <= i + 1'b1;
          end else state <= FIN;
        end else begin
          acc <= sum;
          k <= k + 1'b1;
        end
        FIN: begin
          q <= res;
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tri_gram_mult.sv
// tb_tri_gram_mult: randomized and directed checks of tri_gram_mult against a matrix-product model.
module tb_tri_gram_mult;
  localparam int N = 3, W = 8, AW = 20;
  localparam int LB = W*N*N, AB = AW*N*N;
  logic clk = 0, rst = 1, start = 0, busy, done;
  logic [LB-1:0] L = '0;
  logic [AB-1:0] A;
  int errors = 0, checks = 0;

  tri_gram_mult #(.N(N), .W(W), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .L_inv_in(L),
    .busy(busy), .done(done), .A_inv_out(A)
  );

  always #5 clk = ~clk;

  function automatic logic [LB-1:0] mk_l(input int v [9]);
    logic [LB-1:0] m;
    for (int b = 0; b < 9; b++) m[W*b +: W] = W'(v[b]);
    return m;
  endfunction

  function automatic logic [AB-1:0] mk_a(input int v [9]);
    logic [AB-1:0] m;
    for (int b = 0; b < 9; b++) m[AW*b +: AW] = AW'(v[b]);
    return m;
  endfunction

  // full Linv^T * Linv over the lower-triangular part of the input
  function automatic logic [AB-1:0] model(input logic [LB-1:0] m);
    int l [N][N];
    logic [AB-1:0] a;
    int s;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        l[r][c] = (c <= r) ? int'($signed(m[W*(r*N+c) +: W])) : 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        s = 0;
        for (int t = 0; t < N; t++) s += l[t][r] * l[t][c];
        a[AW*(r*N+c) +: AW] = AW'(s);
      end
    return a;
  endfunction

  function automatic logic [LB-1:0] rand_l();
    logic [LB-1:0] m;
    for (int b = 0; b < 9; b++) m[W*b +: W] = W'($urandom);
    return m;
  endfunction

  task automatic run(input logic [LB-1:0] m, output int lat, output bit busy_ok);
    L = m;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    lat = -1;
    busy_ok = busy;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = e;
        if (busy) busy_ok = 0;
        break;
      end
      if (!busy) busy_ok = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || A !== '0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b A=%h, want 0 0 0", busy, done, A);
    end
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_identity();
    int lat;
    bit bo;
    run(mk_l('{1,0,0, 0,1,0, 0,0,1}), lat, bo);
    checks++;
    if (lat !== 11) begin errors++; $display("FAIL identity_latency: got %0d want 11", lat); end
    checks++;
    if (!bo) begin errors++; $display("FAIL identity_busy: busy got %b want 1 through run", bo); end
    checks++;
    if (A !== mk_a('{1,0,0, 0,1,0, 0,0,1})) begin
      errors++; $display("FAIL identity_result: got %h want identity", A);
    end
  endtask

  task automatic test_general();
    int lat;
    bit bo;
    logic [AB-1:0] exp_a;
    exp_a = mk_a('{6,1,-1, 1,13,2, -1,2,1});
    run(mk_l('{2,0,0, 1,3,0, -1,2,1}), lat, bo);
    checks++;
    if (lat !== 11 || A !== exp_a) begin
      errors++; $display("FAIL general: lat=%0d A=%h want lat=11 A=%h", lat, A, exp_a);
    end
    @(posedge clk); #1;
    run(mk_l('{2,127,127, 1,3,127, -1,2,1}), lat, bo);
    checks++;
    if (lat !== 11 || A !== exp_a) begin
      errors++; $display("FAIL masking: lat=%0d A=%h want lat=11 A=%h", lat, A, exp_a);
    end
  endtask

  task automatic test_extremes();
    int lat;
    bit bo;
    logic [AB-1:0] exp_a;
    exp_a = mk_a('{49152,32768,16384, 32768,32768,16384, 16384,16384,16384});
    run(mk_l('{-128,0,0, -128,-128,0, -128,-128,-128}), lat, bo);
    checks++;
    if (A !== exp_a) begin
      errors++; $display("FAIL extremes: got %h want %h", A, exp_a);
    end
    checks++;
    if (A[AW-1:0] !== 20'd49152) begin
      errors++; $display("FAIL extremes_p00: got %0d want 49152", A[AW-1:0]);
    end
  endtask

  task automatic test_random();
    int lat;
    bit bo;
    logic [LB-1:0] m;
    for (int t = 0; t < 20; t++) begin
      m = rand_l();
      @(posedge clk); #1;
      run(m, lat, bo);
      checks++;
      if (lat !== 11 || !bo || A !== model(m)) begin
        errors++;
        $display("FAIL random[%0d]: lat=%0d busy_ok=%b A=%h want lat=11 A=%h", t, lat, bo, A, model(m));
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [LB-1:0] m1, m2;
    int lat;
    m1 = rand_l();
    m2 = rand_l();
    @(posedge clk); #1;
    L = m1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    lat = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (done) begin lat = e; break; end
      if (e == 3) begin L = m2; start = 1; end
      if (e == 4) start = 0;
    end
    checks++;
    if (lat !== 11 || A !== model(m1)) begin
      errors++; $display("FAIL ignore_start: lat=%0d A=%h want lat=11 A=%h", lat, A, model(m1));
    end
  endtask

  task automatic test_back_to_back();
    logic [LB-1:0] m1, m2;
    int lat1, lat2;
    m1 = rand_l();
    m2 = rand_l();
    @(posedge clk); #1;
    L = m1;
    start = 1;
    @(posedge clk); #1;
    lat1 = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (done) begin lat1 = e; break; end
    end
    checks++;
    if (lat1 !== 11 || A !== model(m1)) begin
      errors++; $display("FAIL b2b_first: lat=%0d A=%h want lat=11 A=%h", lat1, A, model(m1));
    end
    L = m2;
    lat2 = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (done) begin lat2 = e; break; end
    end
    start = 0;
    checks++;
    if (lat2 !== 12 || A !== model(m2)) begin
      errors++; $display("FAIL b2b_second: gap=%0d A=%h want gap=12 A=%h", lat2, A, model(m2));
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    logic [LB-1:0] m;
    int lat;
    bit bo, seen;
    m = rand_l();
    m[7:0] = 8'd5;
    @(posedge clk); #1;
    L = m;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || A !== '0) begin
      errors++; $display("FAIL reset_mid: busy=%b done=%b A=%h want 0 0 0", busy, done, A);
    end
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL reset_mid_quiet: activity got 1 want 0"); end
    run(m, lat, bo);
    checks++;
    if (lat !== 11 || !bo || A !== model(m)) begin
      errors++; $display("FAIL reset_mid_rerun: lat=%0d A=%h want lat=11 A=%h", lat, A, model(m));
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_general();
    test_extremes();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
